snes_pad_reader: RTL and testbench
==================================

# snes_pad_reader

Console-side reader for a physical SNES controller port: drives the latch and clock lines, samples the serial data line, and presents the decoded 12-button vector in the same bit order that `ds2snes` delivers on `snes_buttons`, so either controller source can feed the same downstream logic. It polls at a fixed rate and also accepts on-demand read requests. It detects whether a standard pad is attached and reports that on `present`.

## Interface
- `FREQ`, 21_600_000, system clock frequency in Hz.
- `POLL_HZ`, 60, automatic poll rate in Hz. Localparam `POLL_CYC = FREQ/POLL_HZ`.
- Localparam `HALF_CYC = (FREQ/1_000_000)*6`, the 6 µs half-period in clocks (126 at default). Requirement: `HALF_CYC >= 4`.
- `clk`  in  1  system clock.
- `I_RSTn`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle read request. It is honoured only in IDLE.
- `joy_latch`  out  1  pad latch, active high.
- `joy_clk`  out  1  pad clock, idles high.
- `joy_data`  in  1  pad serial data, active low, asynchronous to `clk`.
- `buttons`  out  12  active-high `{R, L, X, A, RIGHT, LEFT, DOWN, UP, START, SELECT, Y, B}`.
- `valid`  out  1  one-cycle pulse when `buttons` and `present` update.
- `present`  out  1  a standard pad was detected on the last frame.
- `busy`  out  1  a frame is in progress.

## Operation
- `joy_data` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Poll counter:
  - Counts `clk` cycles and resets to 0 whenever a frame starts.
  - On reaching `POLL_CYC-1` in IDLE, it starts a frame.
  - `start` in IDLE starts a frame immediately.
  - `start` coincident with poll expiry starts exactly one frame.
  - `start` while busy is ignored and is not queued.
- FSM states are IDLE, LATCH, CLK_LO, CLK_HI, DONE. A 5-bit bit index `n` and a half-period counter support the sequence.
  - **IDLE:** `joy_latch=0`, `joy_clk=1`, `busy=0`.
  - **LATCH:** `joy_latch=1` for 2·HALF_CYC cycles. On the last cycle, sample raw bit 0. Then set n=1 and go to CLK_LO.
  - **CLK_LO:** `joy_clk=0` for HALF_CYC cycles, then go to CLK_HI.
  - **CLK_HI:** `joy_clk=1` for HALF_CYC cycles. On the last cycle, sample raw bit n. If n=16, go to DONE; otherwise increment n and go to CLK_LO.
  - **DONE:** one cycle. Update the outputs, pulse `valid`, return to IDLE.
- Raw bits are the line level: 1 means the line is high. There are 17 raw bits, 0–16.
- Decode in DONE:
  - `present = (raw[15:12] == 4'b1111) && (raw[16] == 0)`. A standard pad returns released ID bits, then the line goes low.
  - If `present`, then `buttons[k] = ~raw[k]` for k = 0..11. Serial order is B, Y, SELECT, START, UP, DOWN, LEFT, RIGHT, A, X, L, R.
  - If not present, `buttons = 0`.
- `buttons` and `present` hold their values between DONE cycles.

## Timing
- Reset values: `joy_latch=0`, `joy_clk=1`, `buttons=0`, `valid=0`, `present=0`, `busy=0`, FSM=IDLE, poll counter=0.
- Reset is asynchronous. Asserting it mid-frame forces all outputs to their reset values immediately, with no partial update.
- Frame timing, with the start cycle as cycle 0:
  - `busy=1` from cycle 0 through the DONE cycle.
  - Latch is high for cycles 0..2H−1 (H = HALF_CYC).
  - Clock pulse p (p = 1..16) is low for cycles (2p)H..(2p+1)H−1 and high for cycles (2p+1)H..(2p+2)H−1.
  - Bit p is sampled at cycle (2p+2)H−1.
  - DONE and `valid` occur at cycle 34H. Outputs are visible from cycle 34H+1 onward.
- Frame length is 34H+1 cycles: 4285 at default, which is 198 µs.
- The first automatic frame starts at cycle `POLL_CYC-1` after reset release. Later automatic frames start `POLL_CYC` cycles after the previous frame's start, unless `start` pre-empts.
- Data input latency is 2 synchronizer cycles. Data must be stable on the line at least 3 cycles before each sample point.

## Test plan
Bench setup: FREQ=1_000_000, POLL_HZ=1000, so H=6 and POLL_CYC=1000. The bench drives `joy_data` from a 4021-style pad model that loads while the latch is high, shifts on the rising edge of `joy_clk`, and shifts in 0.

- **Reset and idle:** hold `I_RSTn` low, then release, with `start` low → outputs at reset values. First latch rises at cycle 999. `valid` is seen at frame cycle 204.
- **Button decode:** pad presses B, START, A, R with ID bits released → `buttons=12'h909`, `present=1`, `valid` high for exactly 1 cycle.
- **No pad:** `joy_data` tied high → `present=0`, `buttons=12'h000`.
- **Handshake:**
  - `start` pulsed in IDLE → latch rises on the next cycle.
  - `start` pulsed at frame cycle 50 → ignored; exactly one `valid`; next automatic frame 1000 cycles after the first frame's start.
- **Pulse shape:** check `joy_latch` high exactly 12 cycles, 16 `joy_clk` low pulses of exactly 6 cycles each, and `joy_clk` high between pulses.
- **Reset mid-frame:** assert `I_RSTn` low at frame cycle 100 → `joy_clk=1` and `joy_latch=0` immediately, previous `buttons` cleared to 0, no `valid`. After release, a normal frame completes.

Source files
------------

// File: rtl/snes_pad_reader.sv
// SNES pad reader: drives latch/clock, samples serial data, decodes 12 buttons and pad presence.
// Latency: one frame of 34*HALF_CYC+1 cycles from frame start to the valid pulse; outputs update the cycle after.
// Backpressure: none; start is accepted only in IDLE, otherwise dropped, and valid is a single-cycle pulse.
module snes_pad_reader #(
   parameter int FREQ    = 21_600_000,
   parameter int POLL_HZ = 60
) (
   input  logic        clk,
   input  logic        I_RSTn,
   input  logic        start,
   output logic        joy_latch,
   output logic        joy_clk,
   input  logic        joy_data,
   output logic [11:0] buttons,
   output logic        valid,
   output logic        present,
   output logic        busy
);

   localparam int POLL_CYC = FREQ / POLL_HZ;
   localparam int HALF_CYC = (FREQ / 1_000_000) * 6;
   localparam int PW       = (POLL_CYC > 2) ? $clog2(POLL_CYC) : 1;
   localparam int HW       = $clog2(2 * HALF_CYC);

   localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYC - 1);
   localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_CYC - 1);
   localparam logic [HW-1:0] LATCH_LAST = HW'(2 * HALF_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_CLK_LO,
      S_CLK_HI,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [PW-1:0] poll_q, poll_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [4:0]  n_q, n_d;
   logic [16:0] raw_q, raw_d;
   logic        meta_q, sync_q;
   logic [11:0] buttons_q, buttons_d;
   logic        present_q, present_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic        joy_latch_q, joy_latch_d;
   logic        joy_clk_q, joy_clk_d;
   logic        pad_ok;

   // A standard pad reports four released ID bits, then the line drops after the last shift.
   assign pad_ok = (raw_q[15:12] == 4'hF) && !raw_q[16];

   // Two-flop synchronizer for the asynchronous pad data line.
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= joy_data;
         sync_q <= meta_q;
      end
   end

   // Next-state, counters, sampling and decode; pin outputs are derived from the next state so they are registered.
   always_comb begin
      state_d   = state_q;
      poll_d    = (poll_q == POLL_LAST) ? poll_q : poll_q + PW'(1);
      hcnt_d    = hcnt_q + HW'(1);
      n_d       = n_q;
      raw_d     = raw_q;
      buttons_d = buttons_q;
      present_d = present_q;

      case (state_q)
         S_IDLE: begin
            hcnt_d = '0;
            if (start || (poll_q == POLL_LAST)) begin
               state_d = S_LATCH;
               poll_d  = '0;
               n_d     = 5'd0;
            end
         end
         S_LATCH: begin
            if (hcnt_q == LATCH_LAST) begin
               raw_d[0] = sync_q;
               n_d      = 5'd1;
               hcnt_d   = '0;
               state_d  = S_CLK_LO;
            end
         end
         S_CLK_LO: begin
            if (hcnt_q == HALF_LAST) begin
               hcnt_d  = '0;
               state_d = S_CLK_HI;
            end
         end
         S_CLK_HI: begin
            if (hcnt_q == HALF_LAST) begin
               raw_d[n_q] = sync_q;
               hcnt_d     = '0;
               if (n_q == 5'd16) begin
                  state_d = S_DONE;
               end else begin
                  n_d     = n_q + 5'd1;
                  state_d = S_CLK_LO;
               end
            end
         end
         S_DONE: begin
            hcnt_d    = '0;
            present_d = pad_ok;
            buttons_d = pad_ok ? ~raw_q[11:0] : 12'h000;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      joy_latch_d = (state_d == S_LATCH);
      joy_clk_d   = (state_d != S_CLK_LO);
      busy_d      = (state_d != S_IDLE);
      valid_d     = (state_d == S_DONE);
   end

   // State and output registers; reset clears everything at once, so an aborted frame leaves no partial result.
   always_ff @(posedge clk or negedge I_RSTn) begin
      if (!I_RSTn) begin
         state_q     <= S_IDLE;
         poll_q      <= '0;
         hcnt_q      <= '0;
         n_q         <= 5'd0;
         raw_q       <= '0;
         buttons_q   <= 12'h000;
         present_q   <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         joy_latch_q <= 1'b0;
         joy_clk_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         poll_q      <= poll_d;
         hcnt_q      <= hcnt_d;
         n_q         <= n_d;
         raw_q       <= raw_d;
         buttons_q   <= buttons_d;
         present_q   <= present_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         joy_latch_q <= joy_latch_d;
         joy_clk_q   <= joy_clk_d;
      end
   end

   assign joy_latch = joy_latch_q;
   assign joy_clk   = joy_clk_q;
   assign buttons   = buttons_q;
   assign present   = present_q;
   assign valid     = valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_snes_pad_reader.sv
// Directed bench for snes_pad_reader with a 4021-style pad model on the data line.
// Uses FREQ=1 MHz, POLL_HZ=1 kHz: half period 6 cycles, poll period 1000 cycles.
// Each scenario task checks its own results inline.
module tb_snes_pad_reader;

   logic        clk = 1'b0;
   logic        I_RSTn;
   logic        start;
   logic        joy_latch;
   logic        joy_clk;
   logic        joy_data;
   logic [11:0] buttons;
   logic        valid;
   logic        present;
   logic        busy;

   int errors = 0;
   int checks = 0;

   // Pad model state: word bit k is the line level for serial bit k (0 = pressed).
   logic [15:0] pad_word;
   logic [15:0] sr = 16'hFFFF;
   logic        clk_prev = 1'b1;
   logic        pad_on;

   snes_pad_reader #(.FREQ(1_000_000), .POLL_HZ(1000)) dut (
      .clk       (clk),
      .I_RSTn    (I_RSTn),
      .start     (start),
      .joy_latch (joy_latch),
      .joy_clk   (joy_clk),
      .joy_data  (joy_data),
      .buttons   (buttons),
      .valid     (valid),
      .present   (present),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // 4021 shift register: parallel load while latched, shift on joy_clk rising edge, zeros shift in.
   always @(negedge clk) begin
      if (joy_latch) sr <= pad_word;
      else if (joy_clk && !clk_prev) sr <= {1'b0, sr[15:1]};
      clk_prev <= joy_clk;
   end

   assign joy_data = pad_on ? sr[0] : 1'b1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns the 0-based tick index at which joy_latch is first seen high, or -1.
   task automatic wait_latch(input int limit, output int n);
      n = -1;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (joy_latch) begin
            n = i;
            break;
         end
      end
   endtask

   // Returns ticks elapsed until valid is seen, or -1.
   task automatic wait_valid(input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if (valid) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic run_frame(output int vcyc);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid(300, vcyc);
   endtask

   task automatic test_reset();
      int n;
      I_RSTn = 1'b0;
      start = 1'b0;
      pad_on = 1'b1;
      pad_word = {4'hF, ~12'h909};
      repeat (3) tick();
      checks++; if (joy_latch !== 1'b0) begin errors++; $display("FAIL rst_latch: got %b want 0", joy_latch); end
      checks++; if (joy_clk !== 1'b1) begin errors++; $display("FAIL rst_clk: got %b want 1", joy_clk); end
      checks++; if (buttons !== 12'h000) begin errors++; $display("FAIL rst_buttons: got %h want 000", buttons); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid); end
      checks++; if (present !== 1'b0) begin errors++; $display("FAIL rst_present: got %b want 0", present); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      @(negedge clk);
      I_RSTn = 1'b1;
      wait_latch(1100, n);
      checks++; if (n != 999) begin errors++; $display("FAIL first_latch: got %0d want 999", n); end
      wait_valid(300, n);
      checks++; if (n != 204) begin errors++; $display("FAIL first_valid: got %0d want 204", n); end
   endtask

   task automatic test_button_decode();
      int n;
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL decode_valid_on: got %b want 1", valid); end
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL decode_valid_pulse: got %b want 0", valid); end
      checks++; if (buttons !== 12'h909) begin errors++; $display("FAIL decode_909: got %h want 909", buttons); end
      checks++; if (present !== 1'b1) begin errors++; $display("FAIL decode_present: got %b want 1", present); end
      pad_word = {4'hF, ~12'h6F0};
      run_frame(n);
      checks++; if (n != 204) begin errors++; $display("FAIL start_valid: got %0d want 204", n); end
      tick();
      checks++; if (buttons !== 12'h6F0) begin errors++; $display("FAIL decode_6f0: got %h want 6f0", buttons); end
   endtask

   task automatic test_no_pad();
      int n;
      pad_on = 1'b0;
      run_frame(n);
      tick();
      checks++; if (present !== 1'b0) begin errors++; $display("FAIL nopad_present: got %b want 0", present); end
      checks++; if (buttons !== 12'h000) begin errors++; $display("FAIL nopad_buttons: got %h want 000", buttons); end
      pad_on = 1'b1;
   endtask

   task automatic test_pulse_shape();
      int bad = 0, latch_cnt = 0, pulses = 0, badlen = 0, lo_len = 0;
      logic prev_clk = 1'b1;
      logic exp_latch, exp_clk;
      pad_word = {4'hF, ~12'h909};
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int fc = 0; fc <= 204; fc++) begin
         exp_latch = (fc < 12);
         exp_clk = (fc < 12 || fc >= 204) ? 1'b1 : (((fc / 6) % 2) == 1);
         if (joy_latch !== exp_latch || joy_clk !== exp_clk || busy !== 1'b1) bad++;
         if (joy_latch) latch_cnt++;
         if (!joy_clk) lo_len++;
         if (joy_clk && !prev_clk) begin
            pulses++;
            if (lo_len != 6) badlen++;
            lo_len = 0;
         end
         prev_clk = joy_clk;
         if (fc < 204) tick();
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL shape_cycles: got %0d bad cycles want 0", bad); end
      checks++; if (latch_cnt != 12) begin errors++; $display("FAIL latch_len: got %0d want 12", latch_cnt); end
      checks++; if (pulses != 16) begin errors++; $display("FAIL clk_pulses: got %0d want 16", pulses); end
      checks++; if (badlen != 0) begin errors++; $display("FAIL clk_low_len: got %0d bad pulses want 0", badlen); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL shape_valid: got %b want 1", valid); end
      tick();
      checks++; if (buttons !== 12'h909) begin errors++; $display("FAIL shape_buttons: got %h want 909", buttons); end
   endtask

   task automatic test_non_standard();
      int n;
      pad_word = {4'hE, ~12'h909};
      run_frame(n);
      tick();
      checks++; if (present !== 1'b0) begin errors++; $display("FAIL id_present: got %b want 0", present); end
      checks++; if (buttons !== 12'h000) begin errors++; $display("FAIL id_buttons: got %h want 000", buttons); end
      pad_word = {4'hF, ~12'h909};
   endtask

   task automatic test_handshake();
      int vcnt = 0, next_start = -1, rises = 0, first_rise = -1;
      logic prev_latch;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_idle_busy: got %b want 0", busy); end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (joy_latch !== 1'b1) begin errors++; $display("FAIL hs_latch_next: got %b want 1", joy_latch); end
      prev_latch = joy_latch;
      for (int fc = 1; fc <= 1100; fc++) begin
         start = (fc == 51);
         tick();
         if (valid) vcnt++;
         if (joy_latch && !prev_latch) begin
            next_start = fc;
            prev_latch = joy_latch;
            break;
         end
         prev_latch = joy_latch;
      end
      start = 1'b0;
      checks++; if (vcnt != 1) begin errors++; $display("FAIL busy_start_valids: got %0d want 1", vcnt); end
      checks++; if (next_start != 1000) begin errors++; $display("FAIL auto_period: got %0d want 1000", next_start); end
      vcnt = 0;
      for (int fc = 1; fc <= 1999; fc++) begin
         start = (fc == 1000);
         tick();
         if (valid) vcnt++;
         if (joy_latch && !prev_latch) begin
            rises++;
            if (first_rise < 0) first_rise = fc;
         end
         prev_latch = joy_latch;
      end
      start = 1'b0;
      checks++; if (rises != 1) begin errors++; $display("FAIL coincide_frames: got %0d want 1", rises); end
      checks++; if (first_rise != 1000) begin errors++; $display("FAIL coincide_start: got %0d want 1000", first_rise); end
      checks++; if (vcnt != 2) begin errors++; $display("FAIL coincide_valids: got %0d want 2", vcnt); end
   endtask

   task automatic test_reset_midframe();
      int n, vseen = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (100) tick();
      checks++; if (buttons !== 12'h909) begin errors++; $display("FAIL mid_pre_buttons: got %h want 909", buttons); end
      checks++; if (joy_clk !== 1'b0) begin errors++; $display("FAIL mid_pre_clk: got %b want 0", joy_clk); end
      #2;
      I_RSTn = 1'b0;
      #1;
      checks++; if (joy_clk !== 1'b1) begin errors++; $display("FAIL mid_clk: got %b want 1", joy_clk); end
      checks++; if (joy_latch !== 1'b0) begin errors++; $display("FAIL mid_latch: got %b want 0", joy_latch); end
      checks++; if (buttons !== 12'h000) begin errors++; $display("FAIL mid_buttons: got %h want 000", buttons); end
      checks++; if (present !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_pres_busy: got %b%b want 00", present, busy); end
      for (int i = 0; i < 5; i++) begin
         tick();
         if (valid) vseen++;
      end
      checks++; if (vseen != 0) begin errors++; $display("FAIL mid_no_valid: got %0d want 0", vseen); end
      @(negedge clk);
      I_RSTn = 1'b1;
      wait_latch(1100, n);
      checks++; if (n != 999) begin errors++; $display("FAIL mid_relatch: got %0d want 999", n); end
      wait_valid(300, n);
      checks++; if (n != 204) begin errors++; $display("FAIL mid_revalid: got %0d want 204", n); end
      tick();
      checks++; if (buttons !== 12'h909 || present !== 1'b1) begin errors++; $display("FAIL mid_recover: got %h/%b want 909/1", buttons, present); end
   endtask

   initial begin
      I_RSTn = 1'b0;
      start = 1'b0;
      pad_on = 1'b1;
      pad_word = {4'hF, ~12'h909};
      test_reset();
      test_button_decode();
      test_no_pad();
      test_pulse_shape();
      test_non_standard();
      test_handshake();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
